// File: rtl/ls368a_bus_pkg.sv
// Shared types and constants for the ls368a bus receive path.
package ls368a_bus_pkg;

  // Lane split of the hex bus: group 1 owns the low lanes, group 2 the high.
  localparam int G1_LANES = 4;
  localparam int G2_LANES = 2;
  localparam int BUS_W    = G1_LANES + G2_LANES;

  // Window tracking states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    CAPTURE = 2'd2
  } rx_state_t;

  // One buffered word: restored data plus which groups were driven.
  typedef struct packed {
    logic [BUS_W-1:0] data;
    logic [1:0]       mask;
  } fifo_word_t;

endpackage

// File: rtl/ls368a_bus_rx_fifo.sv
// Small word FIFO with a registered head (valid/ready pop), overflow drop
// and a sticky overflow flag.
module bus_word_fifo
  import ls368a_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       push,
  input  fifo_word_t push_word,
  input  logic       pop_ready,
  input  logic       clr_ovf,
  output fifo_word_t head_word,
  output logic       head_valid,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fifo_word_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]       rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]       count_reg, count_next;
  fifo_word_t          head_reg, head_next;
  logic                valid_reg, valid_next;
  logic                ovf_reg, ovf_next;
  logic                full, pop, push_ok, drop, bypass;

  assign full    = (count_reg == FULL_COUNT);
  assign pop     = valid_reg & pop_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Next pointers, occupancy and the word that will sit at the head.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (pop)     rd_ptr_next = rd_ptr_reg + AW'(1);
    if (push_ok && !pop)      count_next = count_reg + CW'(1);
    else if (!push_ok && pop) count_next = count_reg - CW'(1);
    valid_next = (count_next != '0);
    // The new head slot is being written this cycle: forward the push word.
    bypass     = push_ok && (wr_ptr_reg == rd_ptr_next);
    if (!valid_next)  head_next = '0;
    else if (bypass)  head_next = push_word;
    else              head_next = mem[rd_ptr_next];
    // Set wins over clear when both happen together.
    ovf_next = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_reg);
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_word;
  end

  // Pointer, count, head and flag registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
      valid_reg  <= valid_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign head_word  = head_reg;
  assign head_valid = valid_reg;
  assign overflow   = ovf_reg;

endmodule

// File: rtl/ls368a_bus_rx.sv
// Receive end of the ls368a inverting 3-state bus: synchronizes the pins,
// tracks each enable window, restores polarity and buffers words.
module ls368a_bus_rx
  import ls368a_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int MIN_ACTIVE  = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [BUS_W-1:0] bus_in,
  input  logic             e1_b,
  input  logic             e2_b,
  output logic [BUS_W-1:0] out_data,
  output logic [1:0]       out_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             busy
);

  localparam int NIN   = BUS_W + 2;
  localparam int CNT_W = $clog2(MIN_ACTIVE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_ACTIVE);

  logic [NIN-1:0]         raw_in, sync_out;
  logic [SYNC_STAGES-1:0] sync_reg [NIN];
  logic [BUS_W-1:0]       s_bus;
  logic                   s_e1_b, s_e2_b;

  rx_state_t              state_reg, state_next;
  logic [BUS_W-1:0]       cap_reg, cap_next;
  logic [1:0]             mask_reg, mask_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic                   push;
  fifo_word_t             push_word, head_word;

  assign raw_in = {e2_b, e1_b, bus_in};

  generate
    for (genvar gi = 0; gi < NIN; gi++) begin : g_sync
      // Per-input synchronizer chain, preset to the pulled-up idle level.
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) sync_reg[gi] <= '1;
        else        sync_reg[gi] <= {sync_reg[gi][SYNC_STAGES-2:0], raw_in[gi]};
      end
      assign sync_out[gi] = sync_reg[gi][SYNC_STAGES-1];
    end
  endgenerate

  assign s_bus  = sync_out[BUS_W-1:0];
  assign s_e1_b = sync_out[BUS_W];
  assign s_e2_b = sync_out[BUS_W+1];

  // Window FSM next-state, capture and glitch-filter counter.
  always_comb begin
    state_next = state_reg;
    cap_next   = cap_reg;
    mask_next  = mask_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        cap_next  = '0;
        mask_next = '0;
        cnt_next  = '0;
        if (!s_e1_b || !s_e2_b) state_next = ACTIVE;
      end
      ACTIVE: begin
        if (!s_e1_b) begin
          cap_next[G1_LANES-1:0] = ~s_bus[G1_LANES-1:0];
          mask_next[0]           = 1'b1;
        end
        if (!s_e2_b) begin
          cap_next[BUS_W-1:G1_LANES] = ~s_bus[BUS_W-1:G1_LANES];
          mask_next[1]               = 1'b1;
        end
        if (cnt_reg < CNT_MAX) cnt_next = cnt_reg + CNT_W'(1);
        // Short windows are treated as glitches and dropped silently.
        if (s_e1_b && s_e2_b) state_next = (cnt_reg >= CNT_MAX) ? CAPTURE : IDLE;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM and capture registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      cap_reg   <= '0;
      mask_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cap_reg   <= cap_next;
      mask_reg  <= mask_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign push           = (state_reg == CAPTURE);
  assign push_word.data = cap_reg;
  assign push_word.mask = mask_reg;
  assign busy           = (state_reg != IDLE);

  bus_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .push       (push),
    .push_word  (push_word),
    .pop_ready  (out_ready),
    .clr_ovf    (clr_ovf),
    .head_word  (head_word),
    .head_valid (out_valid),
    .overflow   (overflow)
  );

  assign out_data = head_word.data;
  assign out_mask = head_word.mask;

endmodule

// File: doc/ls368a_bus_rx.md
Name: ls368a_bus_rx

Overview:
- Receive end of the hex 3-state inverting bus built from ls368a drivers. Samples the shared 6-line bus, which is resolved by pull-ups and carries inverted data, together with the two active-low group enables.
- Detects each transfer window, restores true polarity and buffers completed words in a small FIFO.
- Downstream logic reads words through a valid/ready handshake. The block sits between the asynchronous bus pins and the clocked core.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every bus and enable input (min 2)
- FIFO_DEPTH, 4, output word buffer depth (power of 2, min 2)
- MIN_ACTIVE, 2, minimum synchronized cycles an enable must be low for a window to count (glitch filter)

Ports:
- clk  input  1  single system clock
- rst_b  input  1  asynchronous active-low reset
- bus_in  input  6  bus lines, active-low data; bits 3:0 = group 1 lanes, bits 5:4 = group 2 lanes
- e1_b  input  1  observed group-1 enable, active low
- e2_b  input  1  observed group-2 enable, active low
- out_data  output  6  true-polarity received word
- out_mask  output  2  bit0 = group 1 was driven this window, bit1 = group 2 was driven
- out_valid  output  1  FIFO head holds a word
- out_ready  input  1  consumer accepts head word
- overflow  output  1  sticky: a window was dropped because the FIFO was full
- clr_ovf  input  1  clears overflow
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous on rst_b low:
  - Synchronizer flops are set to 1 (bus idle, pulled up).
  - FIFO is emptied. FSM goes to IDLE.
  - out_valid=0, out_data=0, out_mask=0, overflow=0, busy=0.
- Synchronization: all 8 inputs pass through SYNC_STAGES flops. All later logic uses only the synchronized copies (s_bus, s_e1_b, s_e2_b).
- FSM states:
  - IDLE: go to ACTIVE when s_e1_b==0 or s_e2_b==0. Clear the capture register, the mask and the low-cycle counter.
  - ACTIVE: each cycle:
    - For each group whose enable is low, load that group's lanes of the capture register with ~s_bus and set its mask bit.
    - Increment the low-cycle counter, saturating at MIN_ACTIVE.
    - When both enables are high: go to CAPTURE if the counter is at least MIN_ACTIVE, otherwise go to IDLE and discard the window silently.
  - CAPTURE: one cycle. Push {capture, mask} into the FIFO, then go to IDLE. Lanes of an undriven group read 0.
- Re-entry: if an enable is low again in the CAPTURE cycle, the FSM still goes to IDLE first and starts a new window on the next cycle. No window is lost, because enables hold for at least MIN_ACTIVE cycles.
- Latency: out_valid rises on the second clk edge after the FSM sees both enables high in ACTIVE, i.e. SYNC_STAGES+2 edges after the pins release, when the FIFO was empty.
- FIFO:
  - out_data, out_mask and out_valid reflect the head word. They are registered and stable while out_valid=1 and out_ready=0.
  - A pop occurs when out_valid and out_ready are both 1.
  - Push while full with a simultaneous pop: the push succeeds.
  - Push while full with no pop: the word is dropped, overflow is set and FIFO contents are unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- overflow: set-dominant over clr_ovf in the same cycle. Otherwise clr_ovf clears it.
- Reset asserted mid-window: the partial window is discarded. No push follows deassertion unless a fresh enable-low edge is seen.

Decomposition:
- Package ls368a_bus_pkg holds:
  - fsm state enum (IDLE, ACTIVE, CAPTURE)
  - lane constants: G1_LANES=4, G2_LANES=2, BUS_W=6
  - fifo word struct {data[5:0], mask[1:0]}
- One sub-module, bus_word_fifo: parameterized synchronous FIFO with valid/ready pop, push/full/overflow-drop and async active-low reset.

Test Plan:
- Single group-1 transfer: e1_b low for 4 cycles with bus_in=6'b111010, e2_b high -> one word, out_data=6'b000101, out_mask=2'b01, out_valid at SYNC_STAGES+2 edges after release.
- Both groups: e1_b and e2_b low together, bus_in=6'b010011 -> out_data=6'b101100, out_mask=2'b11. Hold out_ready=0 and check the outputs stay stable.
- Glitch: e2_b low for 1 synchronized cycle with MIN_ACTIVE=2 -> no word, out_valid stays 0, busy returns to 0.
- Overflow: 5 windows with out_ready=0 and FIFO_DEPTH=4 -> 4 words retained in order, overflow=1. Pulse clr_ovf -> 0. Push on a full FIFO with a simultaneous pop -> accepted, no overflow.
- Reset mid-window: rst_b low while e1_b is low, release after the enable goes high -> no word produced, all outputs at reset values.
- Back-to-back windows separated by one idle cycle -> two distinct words in order with the correct masks.
